aurora_hls_nfc_ctrl: RTL
========================

// Module: aurora_hls_nfc_ctrl
// PURPOSE
//  Parametrised native-flow-control (NFC) generator for the Aurora RX path.
//  Compares the RX FIFO fill level against runtime XOFF/XON thresholds with hysteresis.
//  Issues XOFF/XON messages on the AXI-Stream NFC port, optionally refreshing XOFF while paused.
//  Keeps saturating statistics. Sits between the RX FIFO and the Aurora core NFC slave port.
// PARAMETERS
//  LEVEL_W    10        width of fifo_level and both thresholds
//  REFRESH_W  16        width of refresh_period and of the refresh timer
//  CNT_W      32        width of all statistics counters
//  XOFF_CODE  16'hFFFF  NFC tdata for XOFF (big-endian [0:15])
//  XON_CODE   16'h0000  NFC tdata for XON
// PORTS
//  clk               in   1          clock
//  rst_n             in   1          reset, synchronous, active-low
//  counter_reset     in   1          synchronous clear of statistics only
//  enable            in   1          permits new XOFF episodes
//  fifo_level        in   LEVEL_W    RX FIFO occupancy
//  thr_xoff          in   LEVEL_W    XOFF when fifo_level >= thr_xoff
//  thr_xon           in   LEVEL_W    XON when fifo_level <= thr_xon
//  refresh_period    in   REFRESH_W  XOFF resend interval in cycles; 0 disables resend
//  rx_tvalid         in   1          RX beat indicator, used for overrun counting
//  s_axi_nfc_tready  in   1          NFC handshake from the core
//  s_axi_nfc_tvalid  out  1          NFC message valid
//  s_axi_nfc_tdata   out  [0:15]     NFC message
//  paused            out  1          1 from XOFF issue until XON is accepted
//  xoff_count        out  CNT_W      episodes started; refreshes excluded
//  xon_count         out  CNT_W      XON messages accepted
//  refresh_count     out  CNT_W      refresh XOFFs issued
//  max_overrun       out  CNT_W      max rx_tvalid beats seen in one paused episode
// BEHAVIOUR
//  Reset (rst_n=0): state=RESET, tvalid=0, tdata=0, paused=0, all counters=0, timer=0.
//  - An in-flight message is dropped. No XON is emitted.
//  - RESET->IDLE on the first cycle with rst_n=1.
//  All outputs are registered. A condition sampled at edge n is visible at edge n+1.
//  FSM transitions:
//  - IDLE: if enable & level>=thr_xoff: go XOFF_SEND, tvalid<=1, tdata<=XOFF_CODE, paused<=1,
//    xoff_count++, overrun<=0.
//  - XOFF_SEND: hold tvalid and tdata stable until tready. On tready: tvalid<=0, go XOFF_HOLD,
//    timer<=0.
//  - XOFF_HOLD: if level<=thr_xon: go XON_SEND, tvalid<=1, tdata<=XON_CODE.
//    Else if refresh_period!=0 & timer==refresh_period-1: go XOFF_SEND, refresh_count++.
//    Else timer++.
//  - XON_SEND: hold until tready. On tready: tvalid<=0, paused<=0, xon_count++,
//    max_overrun<=max(max_overrun, overrun), go IDLE.
//  Overrun: +1 per rx_tvalid cycle while paused, including the cycle of the XON handshake.
//  - Saturates at all-ones.
//  enable=0: blocks only the IDLE->XOFF_SEND transition. A paused episode completes normally.
//  Threshold conflict (thr_xon >= thr_xoff): hysteresis collapses.
//  - XOFF_HOLD with level<=thr_xon still releases; XOFF/XON may alternate.
//  - A new XOFF is never issued before the previous XON is accepted.
//  thr_xoff=0: with enable=1, XOFF is issued from IDLE on the next cycle.
//  Statistics counters saturate at 2^CNT_W-1 and never wrap.
//  counter_reset clears all counters and overrun. It does not affect the FSM, paused, or NFC outputs.
//  - Wins over a same-cycle increment: result is 0.
//  - max_overrun compare on the same cycle as counter_reset yields 0.
//  Level changes while tvalid=1 never alter tdata; a pending message always completes.
// TESTING
//  1. thr_xoff=8, thr_xon=2, level 0->8 -> tvalid=1, tdata=FFFF on next cycle, paused=1, xoff_count=1.
//  2. Hold tready=0 for 5 cycles, level to 9 -> tvalid and tdata stable; on tready, tvalid=0 next cycle.
//  3. refresh_period=4, level held 8 -> resend XOFF every 4 HOLD cycles (+handshake); refresh_count increments.
//  4. 3 rx_tvalid beats while paused, level->2 -> XON 0000 sent, paused=0 after tready, max_overrun=3, xon_count=1.
//  5. rst_n=0 during XOFF_SEND -> tvalid=0, paused=0, counters=0 next cycle; no XON emitted.
//  6. counter_reset on the XON handshake cycle -> xon_count=0, max_overrun=0, FSM reaches IDLE.

Source files
------------

// File: rtl/aurora_hls_nfc_ctrl_if.sv
// NFC message channel between the flow-control generator and the Aurora core.
// The generator is the master: it offers tvalid/tdata and the core answers with tready.
interface aurora_hls_nfc_ctrl_if;
  logic        tvalid;
  logic        tready;
  logic [0:15] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/aurora_hls_nfc_ctrl.sv
// Native flow-control generator: watches RX FIFO fill against XOFF/XON thresholds with
// hysteresis, emits XOFF/XON on the NFC channel, optionally refreshes XOFF, keeps statistics.
module aurora_hls_nfc_ctrl #(
  parameter int          LEVEL_W   = 10,
  parameter int          REFRESH_W = 16,
  parameter int          CNT_W     = 32,
  parameter logic [15:0] XOFF_CODE = 16'hFFFF,
  parameter logic [15:0] XON_CODE  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 counter_reset,
  input  logic                 enable,
  input  logic [LEVEL_W-1:0]   fifo_level,
  input  logic [LEVEL_W-1:0]   thr_xoff,
  input  logic [LEVEL_W-1:0]   thr_xon,
  input  logic [REFRESH_W-1:0] refresh_period,
  input  logic                 rx_tvalid,
  aurora_hls_nfc_ctrl_if.master nfc,
  output logic                 paused,
  output logic [CNT_W-1:0]     xoff_count,
  output logic [CNT_W-1:0]     xon_count,
  output logic [CNT_W-1:0]     refresh_count,
  output logic [CNT_W-1:0]     max_overrun
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_XOFF_SEND,
    ST_XOFF_HOLD,
    ST_XON_SEND
  } state_t;

  state_t               state_q, state_d;
  logic                 tvalid_q, tvalid_d;
  logic [0:15]          tdata_q, tdata_d;
  logic                 paused_d;
  logic [REFRESH_W-1:0] timer_q, timer_d, refresh_last;
  logic [CNT_W-1:0]     overrun_q, overrun_inc, overrun_d;
  logic [CNT_W-1:0]     xoff_d, xon_d, refresh_d, max_d;
  logic                 start_ep, refresh_ev, xon_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign refresh_last = refresh_period - REFRESH_W'(1);
  assign overrun_inc  = (paused && rx_tvalid) ? sat_inc(overrun_q) : overrun_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    paused_d   = paused;
    timer_d    = timer_q;
    start_ep   = 1'b0;
    refresh_ev = 1'b0;
    xon_done   = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (enable && fifo_level >= thr_xoff) begin
          state_d  = ST_XOFF_SEND;
          tvalid_d = 1'b1;
          tdata_d  = XOFF_CODE;
          paused_d = 1'b1;
          start_ep = 1'b1;
        end
      end
      ST_XOFF_SEND: begin
        if (nfc.tready) begin
          tvalid_d = 1'b0;
          timer_d  = '0;
          state_d  = ST_XOFF_HOLD;
        end
      end
      ST_XOFF_HOLD: begin
        // Release takes priority over refresh, so colliding thresholds still terminate.
        if (fifo_level <= thr_xon) begin
          state_d  = ST_XON_SEND;
          tvalid_d = 1'b1;
          tdata_d  = XON_CODE;
        end else if (refresh_period != '0 && timer_q == refresh_last) begin
          state_d    = ST_XOFF_SEND;
          tvalid_d   = 1'b1;
          tdata_d    = XOFF_CODE;
          refresh_ev = 1'b1;
        end else begin
          timer_d = timer_q + REFRESH_W'(1);
        end
      end
      ST_XON_SEND: begin
        if (nfc.tready) begin
          tvalid_d = 1'b0;
          paused_d = 1'b0;
          xon_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Statistics; a same-cycle counter_reset beats any increment or max update.
  always_comb begin
    xoff_d    = xoff_count;
    xon_d     = xon_count;
    refresh_d = refresh_count;
    max_d     = max_overrun;
    overrun_d = overrun_inc;
    if (counter_reset) begin
      xoff_d    = '0;
      xon_d     = '0;
      refresh_d = '0;
      max_d     = '0;
      overrun_d = '0;
    end else begin
      if (start_ep) begin
        xoff_d    = sat_inc(xoff_count);
        overrun_d = '0;
      end
      if (refresh_ev) refresh_d = sat_inc(refresh_count);
      if (xon_done) begin
        xon_d = sat_inc(xon_count);
        if (overrun_inc > max_overrun) max_d = overrun_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RESET;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      paused        <= 1'b0;
      timer_q       <= '0;
      overrun_q     <= '0;
      xoff_count    <= '0;
      xon_count     <= '0;
      refresh_count <= '0;
      max_overrun   <= '0;
    end else begin
      state_q       <= state_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      paused        <= paused_d;
      timer_q       <= timer_d;
      overrun_q     <= overrun_d;
      xoff_count    <= xoff_d;
      xon_count     <= xon_d;
      refresh_count <= refresh_d;
      max_overrun   <= max_d;
    end
  end

  assign nfc.tvalid = tvalid_q;
  assign nfc.tdata  = tdata_q;

endmodule
